xsw_modport: RTL and testbench

- 8-port packet crossbar switch ("Xwitch"): 8 ingress lanes, 8 egress lanes, one output FIFO per egress lane.
- Each ingress word is an {8-bit address, 8-bit data} pair. It is routed to the egress port whose programmed address matches.
- Egress ports expose a show-ahead FIFO head, a ready flag and FIFO status flags.
- Sits between upstream packet sources and downstream consumers; port addresses are programmed through a small config bus.

---
 rtl/xsw_modport.sv | 135 +++++++++++++
 tb/tb_xsw_modport.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xsw_modport.sv
// 8-port address-routed crossbar: each ingress word is steered to the egress port whose
// programmed address matches, and each egress port queues into a show-ahead FIFO.
module xsw_modport #(
    parameter int NPORTS   = 8,
    parameter int DEPTH    = 16,
    parameter int AE_LEVEL = 2,
    parameter int AF_LEVEL = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr_in,
    input  logic [63:0] data_in,
    input  logic [7:0]  wr_en,
    output logic [7:0]  data_rcv,
    output logic [63:0] addr_out,
    output logic [63:0] data_out,
    output logic [7:0]  data_rdy,
    input  logic [7:0]  rd_en,
    input  logic        port_en,
    input  logic        port_wr,
    input  logic [7:0]  port_sel,
    input  logic [15:0] port_addr,
    output logic [7:0]  fifo_empty,
    output logic [7:0]  fifo_full,
    output logic [7:0]  fifo_ae,
    output logic [7:0]  fifo_af
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(NPORTS);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [7:0]        paddr     [NPORTS];
    logic [15:0]       mem       [NPORTS][DEPTH];
    logic [PW-1:0]     wptr      [NPORTS];
    logic [PW-1:0]     rptr      [NPORTS];
    logic [CW-1:0]     count     [NPORTS];
    logic [CW-1:0]     count_nxt [NPORTS];
    logic [15:0]       win_word  [NPORTS];
    logic [NPORTS-1:0] claimed;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] accept;
    logic              hit;
    logic [SW-1:0]     tgt;
    logic              unused_bits;

    assign unused_bits = ^port_addr[15:8];

    // Lanes are visited in ascending order, so the first lane to claim an egress port wins.
    // A winner aimed at a full FIFO still blocks the losers, which are simply dropped.
    always_comb begin
        claimed = '0;
        accept  = '0;
        hit     = 1'b0;
        tgt     = '0;
        for (int j = 0; j < NPORTS; j++) win_word[j] = '0;
        for (int i = 0; i < NPORTS; i++) begin
            hit = 1'b0;
            tgt = '0;
            if (wr_en[i]) begin
                for (int j = NPORTS - 1; j >= 0; j--) begin
                    if (paddr[j] == addr_in[8*i +: 8]) begin
                        hit = 1'b1;
                        tgt = SW'(j);
                    end
                end
            end
            if (hit && !claimed[tgt]) begin
                claimed[tgt]  = 1'b1;
                win_word[tgt] = {addr_in[8*i +: 8], data_in[8*i +: 8]};
                accept[i]     = (count[tgt] != FULL_CNT);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            push[j] = claimed[j] && (count[j] != FULL_CNT);
            pop[j]  = rd_en[j] && (count[j] != '0);
            case ({push[j], pop[j]})
                2'b10:   count_nxt[j] = count[j] + 1'b1;
                2'b01:   count_nxt[j] = count[j] - 1'b1;
                default: count_nxt[j] = count[j];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_rcv   <= '0;
            fifo_empty <= '1;
            fifo_ae    <= '1;
            fifo_full  <= '0;
            fifo_af    <= '0;
            for (int j = 0; j < NPORTS; j++) begin
                paddr[j] <= 8'(j);
                wptr[j]  <= '0;
                rptr[j]  <= '0;
                count[j] <= '0;
            end
        end else begin
            data_rcv <= accept;
            for (int j = 0; j < NPORTS; j++) begin
                if (port_en && port_wr && port_sel[j]) paddr[j] <= port_addr[7:0];
                if (push[j]) wptr[j] <= wptr[j] + 1'b1;
                if (pop[j])  rptr[j] <= rptr[j] + 1'b1;
                count[j]      <= count_nxt[j];
                fifo_empty[j] <= (count_nxt[j] == '0);
                fifo_full[j]  <= (count_nxt[j] == FULL_CNT);
                fifo_ae[j]    <= (count_nxt[j] <= AE_CNT);
                fifo_af[j]    <= (count_nxt[j] >= AF_CNT);
            end
        end
    end

    // Storage carries no reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NPORTS; j++) begin
            if (push[j]) mem[j][wptr[j]] <= win_word[j];
        end
    end

    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            addr_out[8*j +: 8] = (count[j] != '0) ? mem[j][rptr[j]][15:8] : 8'h00;
            data_out[8*j +: 8] = (count[j] != '0) ? mem[j][rptr[j]][7:0]  : 8'h00;
        end
    end

    assign data_rdy = ~fifo_empty;

endmodule

// File: tb/tb_xsw_modport.sv
// Directed bench for xsw_modport: routing, config, arbitration, FIFO fill/drain, flags, reset.
module tb_xsw_modport;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr_in, data_in, addr_out, data_out;
    logic [7:0]  wr_en, data_rcv, data_rdy, rd_en, port_sel;
    logic [7:0]  fifo_empty, fifo_full, fifo_ae, fifo_af;
    logic        port_en, port_wr;
    logic [15:0] port_addr;
    int          checks = 0;
    int          errors = 0;

    xsw_modport dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
        .data_rcv(data_rcv), .addr_out(addr_out), .data_out(data_out), .data_rdy(data_rdy),
        .rd_en(rd_en), .port_en(port_en), .port_wr(port_wr), .port_sel(port_sel),
        .port_addr(port_addr), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_ae(fifo_ae), .fifo_af(fifo_af)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; rd_en = '0; addr_in = '0; data_in = '0;
        port_en = 1'b0; port_wr = 1'b0; port_sel = '0; port_addr = '0;
    endtask

    task automatic send(input int lane, input logic [7:0] a, input logic [7:0] d);
        wr_en[lane] = 1'b1;
        addr_in[8*lane +: 8] = a;
        data_in[8*lane +: 8] = d;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (fifo_empty !== 8'hFF || fifo_ae !== 8'hFF || fifo_full !== 8'h00 || fifo_af !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got empty=%h ae=%h full=%h af=%h required FF FF 00 00",
                     fifo_empty, fifo_ae, fifo_full, fifo_af);
        end
        checks++;
        if (data_rdy !== 8'h00 || data_rcv !== 8'h00 || addr_out !== 64'h0 || data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%h rcv=%h addr=%h data=%h required all zero",
                     data_rdy, data_rcv, addr_out, data_out);
        end
    endtask

    task automatic test_basic_route();
        send(3, 8'h05, 8'hA5);
        step();
        idle();
        checks++;
        if (data_rdy !== 8'h20 || addr_out[47:40] !== 8'h05 || data_out[47:40] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_route: got rdy=%h addr5=%h data5=%h required 20 05 A5",
                     data_rdy, addr_out[47:40], data_out[47:40]);
        end
        checks++;
        if (data_rcv !== 8'h08) begin
            errors++;
            $display("FAIL basic_ack: got %h required 08", data_rcv);
        end
        step();
        checks++;
        if (data_rcv !== 8'h00) begin
            errors++;
            $display("FAIL basic_ack_pulse: got %h required 00", data_rcv);
        end
        rd_en[5] = 1'b1;
        step();
        idle();
        checks++;
        if (fifo_empty[5] !== 1'b1 || data_out[47:40] !== 8'h00 || addr_out[47:40] !== 8'h00) begin
            errors++;
            $display("FAIL basic_pop: got empty5=%b data5=%h addr5=%h required 1 00 00",
                     fifo_empty[5], data_out[47:40], addr_out[47:40]);
        end
    endtask

    task automatic test_config();
        port_en = 1'b1; port_wr = 1'b1; port_sel = 8'h04; port_addr = 16'hAB33;
        step();
        port_wr = 1'b0; port_sel = 8'h08; port_addr = 16'h0044;
        step();
        idle();
        send(0, 8'h44, 8'h01);
        step();
        idle();
        checks++;
        if (data_rcv !== 8'h00 || data_rdy !== 8'h00) begin
            errors++;
            $display("FAIL cfg_no_write: got rcv=%h rdy=%h required 00 00", data_rcv, data_rdy);
        end
        send(0, 8'h33, 8'h3C);
        step();
        idle();
        checks++;
        if (data_rcv !== 8'h01 || data_rdy !== 8'h04 || data_out[23:16] !== 8'h3C) begin
            errors++;
            $display("FAIL cfg_route: got rcv=%h rdy=%h data2=%h required 01 04 3C",
                     data_rcv, data_rdy, data_out[23:16]);
        end
        send(0, 8'h02, 8'h77);
        step();
        idle();
        checks++;
        if (data_rcv !== 8'h00 || data_rdy !== 8'h04) begin
            errors++;
            $display("FAIL cfg_old_addr_drop: got rcv=%h rdy=%h required 00 04", data_rcv, data_rdy);
        end
        rd_en[2] = 1'b1;
        step();
        idle();
    endtask

    task automatic test_arbitration();
        send(1, 8'h07, 8'h11);
        send(4, 8'h07, 8'h44);
        send(6, 8'h07, 8'h66);
        step();
        idle();
        checks++;
        if (data_rcv !== 8'h02 || data_out[63:56] !== 8'h11 || data_rdy !== 8'h80) begin
            errors++;
            $display("FAIL arb_winner: got rcv=%h data7=%h rdy=%h required 02 11 80",
                     data_rcv, data_out[63:56], data_rdy);
        end
        rd_en[7] = 1'b1;
        step();
        idle();
        checks++;
        if (fifo_empty[7] !== 1'b1) begin
            errors++;
            $display("FAIL arb_count_one: got empty7=%b required 1 after one pop", fifo_empty[7]);
        end
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 16; k++) begin
            send(0, 8'h00, 8'(k));
            step();
            idle();
            checks++;
            if (data_rcv !== 8'h01 || fifo_af[0] !== (k + 1 >= 14) || fifo_full[0] !== (k == 15)
                || fifo_ae[0] !== (k + 1 <= 2)) begin
                errors++;
                $display("FAIL fill_%0d: got rcv=%h af=%b full=%b ae=%b required 01 %b %b %b", k,
                         data_rcv, fifo_af[0], fifo_full[0], fifo_ae[0], k + 1 >= 14, k == 15, k + 1 <= 2);
            end
        end
        send(0, 8'h00, 8'hEE);
        rd_en[0] = 1'b1;
        step();
        idle();
        checks++;
        if (data_rcv !== 8'h00 || fifo_full[0] !== 1'b0 || data_out[7:0] !== 8'h01) begin
            errors++;
            $display("FAIL full_drop: got rcv=%h full=%b head=%h required 00 0 01",
                     data_rcv, fifo_full[0], data_out[7:0]);
        end
        for (int k = 1; k < 16; k++) begin
            checks++;
            if (data_out[7:0] !== 8'(k) || addr_out[7:0] !== 8'h00) begin
                errors++;
                $display("FAIL drain_order_%0d: got %h required %h", k, data_out[7:0], 8'(k));
            end
            rd_en[0] = 1'b1;
            step();
            idle();
            checks++;
            if (fifo_ae[0] !== (15 - k <= 2) || fifo_empty[0] !== (k == 15)) begin
                errors++;
                $display("FAIL drain_flags_%0d: got ae=%b empty=%b required %b %b", k,
                         fifo_ae[0], fifo_empty[0], 15 - k <= 2, k == 15);
            end
        end
    endtask

    task automatic test_push_pop();
        for (int k = 0; k < 5; k++) begin
            send(0, 8'h33, 8'(8'h20 + k));
            step();
            idle();
        end
        send(0, 8'h33, 8'h99);
        rd_en[2] = 1'b1;
        step();
        idle();
        checks++;
        if (data_rcv !== 8'h01 || fifo_ae[2] !== 1'b0 || fifo_af[2] !== 1'b0 || fifo_empty[2] !== 1'b0
            || data_out[23:16] !== 8'h21) begin
            errors++;
            $display("FAIL push_pop: got rcv=%h ae=%b af=%b empty=%b head=%h required 01 0 0 0 21",
                     data_rcv, fifo_ae[2], fifo_af[2], fifo_empty[2], data_out[23:16]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (data_out[23:16] !== ((k == 4) ? 8'h99 : 8'(8'h21 + k))) begin
                errors++;
                $display("FAIL push_pop_order_%0d: got %h", k, data_out[23:16]);
            end
            rd_en[2] = 1'b1;
            step();
            idle();
        end
        checks++;
        if (fifo_empty[2] !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_count: got empty2=%b required 1 after five pops", fifo_empty[2]);
        end
        rd_en[4] = 1'b1;
        step();
        idle();
        checks++;
        if (fifo_empty !== 8'hFF || fifo_ae !== 8'hFF || data_rdy !== 8'h00 || data_out !== 64'h0) begin
            errors++;
            $display("FAIL empty_read: got empty=%h ae=%h rdy=%h data=%h required FF FF 00 0",
                     fifo_empty, fifo_ae, data_rdy, data_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            send(0, 8'h01, 8'(8'h50 + k));
            step();
            idle();
        end
        checks++;
        if (data_rdy !== 8'h02) begin
            errors++;
            $display("FAIL mid_fill: got rdy=%h required 02", data_rdy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (fifo_empty[1] !== 1'b1 || data_rdy !== 8'h00 || data_out !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset: got empty1=%b rdy=%h data=%h required 1 00 0",
                     fifo_empty[1], data_rdy, data_out);
        end
        send(0, 8'h01, 8'h5A);
        step();
        idle();
        checks++;
        if (data_rdy !== 8'h02 || data_out[15:8] !== 8'h5A) begin
            errors++;
            $display("FAIL mid_paddr1: got rdy=%h data1=%h required 02 5A", data_rdy, data_out[15:8]);
        end
        send(0, 8'h02, 8'hC3);
        step();
        idle();
        checks++;
        if (data_rdy !== 8'h06 || data_out[23:16] !== 8'hC3) begin
            errors++;
            $display("FAIL mid_paddr2: got rdy=%h data2=%h required 06 C3", data_rdy, data_out[23:16]);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_basic_route();
        test_config();
        test_arbitration();
        test_fill_drain();
        test_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
